// File: rtl/rtc_mem_arbiter.sv
// RTC register-file arbiter: buffers converter updates in a small FIFO and
// shares the register-file port with a host using round-robin grants.
module rtc_mem_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] upd_addr,
  input  logic [7:0] upd_data,
  input  logic       upd_we,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [3:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       upd_ovf
);

  typedef enum logic [2:0] {
    S_IDLE, S_UPD, S_HWR, S_HRD, S_HRW, S_HACK, S_HGAP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_fifo [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_level;
  logic        r_prio_host;
  logic        r_ovf;
  logic        r_host_ack;
  logic [7:0]  r_host_rdata;
  logic [3:0]  r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_mem_we;

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic [11:0] w_head;
  logic [3:0]  w_mem_addr;
  logic [7:0]  w_mem_wdata;

  assign w_empty = (r_level == 3'd0);
  assign w_full  = (r_level == 3'd4);
  assign w_head  = r_fifo[r_rptr];
  assign w_push  = upd_we && (!w_full || w_pop);

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && (!host_req || !r_prio_host)) begin
          w_next = S_UPD;
          w_pop  = 1'b1;
        end else if (host_req) begin
          w_next = host_we ? S_HWR : S_HRD;
        end
      end
      S_UPD:   w_next = S_IDLE;
      S_HWR:   w_next = S_HGAP;
      S_HRD:   w_next = S_HRW;
      S_HRW:   w_next = S_HACK;
      S_HACK:  w_next = S_HGAP;
      S_HGAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the next state.
  always_comb begin
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    unique case (1'b1)
      (w_next == S_UPD): begin
        w_mem_addr  = w_head[11:8];
        w_mem_wdata = w_head[7:0];
      end
      (w_next == S_HWR): begin
        w_mem_addr  = host_addr;
        w_mem_wdata = host_wdata;
      end
      (w_next == S_HRD && r_state == S_IDLE): begin
        w_mem_addr  = host_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wptr       <= 2'd0;
      r_rptr       <= 2'd0;
      r_level      <= 3'd0;
      r_prio_host  <= 1'b0;
      r_ovf        <= 1'b0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= 8'd0;
      r_mem_addr   <= 4'd0;
      r_mem_wdata  <= 8'd0;
      r_mem_we     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_we    <= (w_next == S_UPD) || (w_next == S_HWR);
      r_host_ack  <= (w_next == S_HWR) || (w_next == S_HACK);
      if (r_state == S_HRW)
        r_host_rdata <= mem_rdata;
      if (r_state == S_IDLE && w_next != S_IDLE)
        r_prio_host <= (w_next == S_UPD);
      if (w_push)
        r_wptr <= r_wptr + 2'd1;
      if (w_pop)
        r_rptr <= r_rptr + 2'd1;
      r_level <= r_level + {2'b00, w_push} - {2'b00, w_pop};
      if (upd_we && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wptr] <= {upd_addr, upd_data};
  end

  assign host_ack   = r_host_ack;
  assign host_rdata = r_host_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;
  assign upd_ovf    = r_ovf;

endmodule

// File: tb/tb_rtc_mem_arbiter.sv
// Directed and randomized checks of rtc_mem_arbiter against a
// transaction-level model of the register file and update FIFO.
module tb_rtc_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] upd_addr = '0;
  logic [7:0] upd_data = '0;
  logic       upd_we = 1'b0;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata = '0;
  logic       upd_ovf;

  rtc_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .upd_addr(upd_addr), .upd_data(upd_data), .upd_we(upd_we),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .upd_ovf(upd_ovf)
  );

  always #5 clk = ~clk;

  // Register file with synchronous read
  logic [7:0] mem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_ack = 0;
  logic [12:0] evq [$];
  logic        s_ack;
  logic [7:0]  s_rdata;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_ack   = host_ack;
    s_rdata = host_rdata;
    if (mem_we) evq.push_back({host_ack, mem_addr, mem_wdata});
    if (host_ack) n_ack++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},    mem_we,     1'b0);
    chk({tag, "_ack"},   host_ack,   1'b0);
    chk({tag, "_addr"},  mem_addr,   4'h0);
    chk({tag, "_wdata"}, mem_wdata,  8'h00);
    chk({tag, "_rdata"}, host_rdata, 8'h00);
    chk({tag, "_ovf"},   upd_ovf,    1'b0);
  endtask

  logic [7:0]  d6 [6] = '{8'h32, 8'h45, 8'h12, 8'h07, 8'h02, 8'h21};
  logic [11:0] pushq [$];
  logic [7:0]  gm [16];
  logic        gvalid [16];
  logic [12:0] e;
  logic [11:0] x;
  logic        exp_src [$];
  int hd, u, h, lat, last;
  bit turn_host, mono;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    tick(); tick();

    // Host write on an idle block
    host_req = 1; host_we = 1; host_addr = 4'h8; host_wdata = 8'hA5;
    tick();
    chk("hwr_we", mem_we, 1'b1);
    chk("hwr_addr", mem_addr, 4'h8);
    chk("hwr_wdata", mem_wdata, 8'hA5);
    chk("hwr_ack", host_ack, 1'b1);
    host_req = 0;
    tick();
    chk("hgap_ack", host_ack, 1'b0);
    chk("hgap_we", mem_we, 1'b0);
    tick();

    // Preload mem[3]=0x45, then read it back
    host_req = 1; host_we = 1; host_addr = 4'h3; host_wdata = 8'h45;
    tick();
    host_req = 0;
    tick(); tick();
    host_req = 1; host_we = 0; host_addr = 4'h3;
    tick();
    chk("hrd_c1_ack", host_ack, 1'b0);
    chk("hrd_c1_we", mem_we, 1'b0);
    tick();
    chk("hrd_c2_ack", host_ack, 1'b0);
    chk("hrd_c2_we", mem_we, 1'b0);
    tick();
    chk("hrd_c3_ack", host_ack, 1'b1);
    chk("hrd_c3_rdata", host_rdata, 8'h45);
    chk("hrd_c3_we", mem_we, 1'b0);
    host_req = 0;
    tick(); tick();
    chk("rdata_hold", host_rdata, 8'h45);

    // Six back-to-back converter writes
    evq.delete();
    for (int i = 0; i < 6; i++) begin
      upd_we = 1; upd_addr = 4'(i); upd_data = d6[i];
      tick();
    end
    upd_we = 0;
    repeat (15) tick();
    chk("upd6_count", evq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < evq.size()) chk("upd6_event", evq[i], {1'b0, 4'(i), d6[i]});
    end
    chk("upd6_ovf", upd_ovf, 1'b0);

    // Reset in the middle of a host read
    evq.delete();
    host_req = 1; host_we = 0; host_addr = 4'h5;
    tick();
    rst = 1;
    #1;
    check_zero("rst_mid");
    host_req = 0;
    tick();
    rst = 0;
    n_ack = 0;
    repeat (6) tick();
    chk("rst_no_ack", n_ack, 0);
    chk("rst_no_write", evq.size(), 0);

    // Update and host pending together: alternate, update first
    rst = 1; tick(); rst = 0;
    evq.delete();
    hd = 0;
    for (int c = 0; c < 60; c++) begin
      upd_we = (c < 4);
      upd_addr = 4'(4'hA + c);
      upd_data = 8'(8'h10 + c);
      if (c == 1) begin
        host_req = 1; host_we = 1; host_addr = 4'hC; host_wdata = 8'h80;
      end
      tick();
      if (s_ack) begin
        hd++;
        host_wdata = host_wdata + 8'h1;
        if (hd == 3) host_req = 0;
      end
    end
    u = 4; h = 3; turn_host = 0;
    exp_src.delete();
    while (u > 0 || h > 0) begin
      if ((!turn_host && u > 0) || h == 0) begin
        exp_src.push_back(1'b0); u--; turn_host = 1;
      end else begin
        exp_src.push_back(1'b1); h--; turn_host = 0;
      end
    end
    chk("rr_count", evq.size(), 7);
    u = 0; h = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < evq.size()) begin
        chk("rr_src", evq[i][12], exp_src[i]);
        if (!exp_src[i]) begin
          chk("rr_upd", evq[i][11:0], {4'(4'hA + u), 8'(8'h10 + u)});
          u++;
        end else begin
          chk("rr_host", evq[i][11:0], {4'hC, 8'(8'h80 + h)});
          h++;
        end
      end
    end

    // Overflow: ten consecutive pushes
    evq.delete();
    for (int i = 0; i < 10; i++) begin
      upd_we = 1; upd_addr = 4'(i); upd_data = 8'(i);
      tick();
    end
    upd_we = 0;
    repeat (30) tick();
    chk("ovf_set", upd_ovf, 1'b1);
    chk("ovf_dropped", evq.size() < 10, 1'b1);
    mono = 1; last = -1;
    foreach (evq[i]) begin
      if (int'(evq[i][7:0]) <= last) mono = 0;
      last = int'(evq[i][7:0]);
    end
    chk("ovf_order", mono, 1'b1);
    host_req = 1; host_we = 1; host_addr = 4'h1; host_wdata = 8'h5A;
    tick();
    host_req = 0;
    repeat (5) tick();
    chk("ovf_sticky", upd_ovf, 1'b1);
    rst = 1; tick(); rst = 0;
    chk("ovf_clear", upd_ovf, 1'b0);
    tick();

    // Randomized traffic against the transaction model
    evq.delete(); pushq.delete();
    for (int i = 0; i < 16; i++) gvalid[i] = 0;
    lat = 0;
    for (int c = 0; c < 400; c++) begin
      upd_we = (pushq.size() < 4) && ($urandom_range(0, 2) == 0);
      if (upd_we) begin
        upd_addr = 4'($urandom);
        upd_data = 8'($urandom);
        pushq.push_back({upd_addr, upd_data});
      end
      if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req = 1; host_we = 1'($urandom);
        host_addr = 4'($urandom); host_wdata = 8'($urandom);
        lat = 0;
      end
      tick();
      upd_we = 0;
      while (evq.size() > 0) begin
        e = evq.pop_front();
        if (!e[12]) begin
          chk("rnd_upd_pending", pushq.size() > 0, 1'b1);
          if (pushq.size() > 0) begin
            x = pushq.pop_front();
            chk("rnd_upd_write", e[11:0], x);
            gm[x[11:8]] = x[7:0]; gvalid[x[11:8]] = 1;
          end
        end else begin
          chk("rnd_hwr_write", e[11:0], {host_addr, host_wdata});
          chk("rnd_hwr_type", host_we, 1'b1);
          gm[host_addr] = host_wdata; gvalid[host_addr] = 1;
        end
      end
      if (s_ack) begin
        chk("rnd_ack_req", host_req, 1'b1);
        chk("rnd_ack_lat", lat <= 12, 1'b1);
        if (!host_we && gvalid[host_addr])
          chk("rnd_read", s_rdata, gm[host_addr]);
        host_req = 0;
      end else if (host_req) begin
        lat++;
        if (lat > 40) begin
          chk("rnd_host_hang", lat, 40);
          host_req = 0;
        end
      end
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      while (evq.size() > 0) begin
        e = evq.pop_front();
        if (!e[12] && pushq.size() > 0) begin
          x = pushq.pop_front();
          chk("rnd_drain_write", e[11:0], x);
        end
      end
      if (s_ack) host_req = 0;
    end
    chk("rnd_drained", pushq.size(), 0);
    chk("rnd_ovf", upd_ovf, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
